uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL have parameter CLK_SORC, default 50000000, source clock frequency in Hz.
REQ-002 The block SHALL have parameter BUAD_RATE, default 115200, line bit rate.
REQ-003 The block SHALL have parameter CLKS_PER_BIT, default 434, clocks per bit, equal to CLK_SORC/BUAD_RATE rounded down.
REQ-004 The block SHALL have port clk_50m  input  1  the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port data  input  8  byte to send, sampled on accept.
REQ-007 The block SHALL have port valid  input  1  data holds a byte to send.
REQ-008 The block SHALL have port ready  output  1  block can accept a byte this cycle.
REQ-009 The block SHALL have port tx  output  1  serial line, idle high, feeds the receiver's rx.
REQ-010 The block SHALL have port busy  output  1  a frame is in progress.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse when a frame's stop bit completes.

Function
REQ-012 The block SHALL accept a byte on the rising edge where valid and ready are both high, latching data into an internal shift register.
REQ-013 Changes on data after accept SHALL NOT affect the frame in progress.
REQ-014 ready SHALL be high only in ST_IDLE; a valid asserted while not ready SHALL be ignored, with no queuing.
REQ-015 The state machine SHALL have the states ST_IDLE, ST_START, ST_DATA, ST_PARITY (macro only) and ST_STOP.
REQ-016 Transitions SHALL be: IDLE->START on accept; START->DATA after CLKS_PER_BIT cycles; DATA->STOP (or PARITY) after 8 bits; PARITY->STOP; STOP->IDLE after CLKS_PER_BIT cycles.
REQ-017 tx SHALL go low on the cycle after accept (latency 1 clock), and each bit SHALL be held exactly CLKS_PER_BIT cycles.
REQ-018 Data bits SHALL be sent LSB first, followed by one stop bit (high).
REQ-019 The bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0 at every bit boundary.
REQ-020 The bit index SHALL be 3 bits wide and count 0..7.
REQ-021 Frame length SHALL be 10*CLKS_PER_BIT cycles without parity (4340 at defaults).
REQ-022 done SHALL pulse for one cycle on the last cycle of ST_STOP; ready SHALL be high on the following cycle.
REQ-023 With valid held high, the next frame's start bit SHALL begin 1 cycle after ready rises, giving back-to-back frames with no extra idle bits.
REQ-024 busy SHALL equal NOT ready.
REQ-025 tx SHALL be registered, with no combinational path from any input to tx.

Reset
REQ-026 On rst_n low, at any time including mid-frame, the block SHALL immediately set: state ST_IDLE, tx=1, ready=1, busy=0, done=0, counters=0, shift register=0.
REQ-027 A frame interrupted by reset SHALL be abandoned, not resumed.
REQ-028 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-029 With UART_TX_PARITY_EN defined, the block SHALL insert an even-parity bit (XOR of the 8 data bits) between the last data bit and the stop bit, giving a frame of 11*CLKS_PER_BIT cycles.
REQ-030 Without UART_TX_PARITY_EN, ST_PARITY and its logic SHALL be absent and the frame SHALL be 8N1.

Structure
REQ-031 The shared package uart_pkg SHALL hold the state encoding (ST_IDLE..ST_STOP), the default CLK_SORC/BUAD_RATE values and the frame bit-count constants, for reuse by the receiver side.
REQ-032 The single sub-module uart_baud_gen SHALL produce a one-cycle bit tick every CLKS_PER_BIT cycles, restarted on accept; all other logic SHALL stay in uart_transmitter.

Verification
REQ-033 Reset, then a single byte: valid=1 with data=8'h55 for one cycle -> tx low from the next cycle for 434 cycles, then 1,0,1,0,1,0,1,0 at 434 cycles each, stop high, done pulse at cycle 4340.
REQ-034 Back-to-back: valid held high with data=8'hA3 then 8'h0F -> two contiguous frames with no idle between stop and start; loopback into the receiver yields rdy with data 8'hA3 then 8'h0F.
REQ-035 Busy ignore: send 8'hFF, then pulse valid with 8'h00 mid-frame -> no second frame; tx stays high after stop; ready=0 throughout the frame.
REQ-036 Reset mid-frame: assert rst_n=0 during bit 3 of 8'h81 -> tx=1 and ready=1 asynchronously; a new byte 8'h3C after release transmits correctly.
REQ-037 Parity build (UART_TX_PARITY_EN): 8'h07 -> parity bit 1 and frame length 4774 cycles; 8'h03 -> parity bit 0.
REQ-038 Data change after accept: toggle data every cycle after accepting 8'hC6 -> the serialized bits still match 8'hC6.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and state encoding
//
// Purpose : shared between the transmitter and the receiver side. Holds the
//           default clock/bit-rate values, the frame bit counts and the
//           transmit state encoding.
// Ports   : none (package)
// Config  : UART_TX_PARITY_EN adds ST_PARITY and one parity bit per frame.

package uart_pkg;

   localparam int DEFAULT_CLK_SORC  = 50_000_000;
   localparam int DEFAULT_BUAD_RATE = 115_200;

   localparam int START_BITS = 1;
   localparam int DATA_BITS  = 8;
   localparam int STOP_BITS  = 1;
`ifdef UART_TX_PARITY_EN
   localparam int PARITY_BITS = 1;
`else
   localparam int PARITY_BITS = 0;
`endif
   localparam int FRAME_BITS = START_BITS + DATA_BITS + PARITY_BITS + STOP_BITS;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter producing one tick per bit
//
// Purpose : counts 0..CLKS_PER_BIT-1 while a frame runs and pulses tick on the
//           last cycle of each bit period. restart zeroes the count so the
//           first bit period starts on the cycle after an accept.
// Ports   : clk_50m  in   clock, rising edge
//           rst_n    in   asynchronous active-low reset
//           run      in   frame in progress; count held at 0 when low
//           restart  in   byte accepted this cycle; count restarts at 0
//           tick     out  last cycle of the current bit period
//           bit_cnt  out  current position inside the bit period

module uart_baud_gen #(
   parameter  int CLKS_PER_BIT = 434,
   localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic             clk_50m,
   input  logic             rst_n,
   input  logic             run,
   input  logic             restart,
   output logic             tick,
   output logic [CNT_W-1:0] bit_cnt
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   assign tick = run && (bit_cnt == LAST_CNT);

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= '0;
      end else if (restart || !run || bit_cnt == LAST_CNT) begin
         bit_cnt <= '0;
      end else begin
         bit_cnt <= bit_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 UART transmitter with valid/ready byte input
//
// Purpose : serialises one byte per frame, LSB first, start bit low, stop bit
//           high. A byte is taken when valid and ready are both high.
// Ports   : clk_50m  in   clock, rising edge
//           rst_n    in   asynchronous active-low reset, abandons any frame
//           data     in   byte to send, sampled on accept
//           valid    in   data holds a byte to send
//           ready    out  idle, a byte can be accepted this cycle
//           tx       out  registered serial line, idle high
//           busy     out  frame in progress (inverse of ready)
//           done     out  one-cycle pulse on the last cycle of the stop bit
// Config  : define UART_TX_PARITY_EN for an even-parity bit before the stop bit.

module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLK_SORC     = DEFAULT_CLK_SORC,
   parameter int BUAD_RATE    = DEFAULT_BUAD_RATE,
   parameter int CLKS_PER_BIT = CLK_SORC / BUAD_RATE
) (
   input  logic       clk_50m,
   input  logic       rst_n,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   // done is registered, so it is raised one cycle before the stop-bit tick
   localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(CLKS_PER_BIT - 2);

   uart_state_t      state;
   logic [7:0]       shreg;
   logic [2:0]       bit_idx;
   logic             tick;
   logic [CNT_W-1:0] bit_cnt;
   logic             accept;
`ifdef UART_TX_PARITY_EN
   logic             parity;
`endif

   assign accept = valid && ready;
   assign busy   = ~ready;

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_gen (
      .clk_50m (clk_50m),
      .rst_n   (rst_n),
      .run     (state != ST_IDLE),
      .restart (accept),
      .tick    (tick),
      .bit_cnt (bit_cnt)
   );

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         tx      <= 1'b1;
         ready   <= 1'b1;
         done    <= 1'b0;
         shreg   <= '0;
         bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
         parity  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  shreg   <= data;
                  bit_idx <= '0;
                  tx      <= 1'b0;
                  ready   <= 1'b0;
                  state   <= ST_START;
`ifdef UART_TX_PARITY_EN
                  parity  <= ^data;
`endif
               end
            end
            ST_START: begin
               if (tick) begin
                  tx    <= shreg[0];
                  shreg <= shreg >> 1;
                  state <= ST_DATA;
               end
            end
            ST_DATA: begin
               // bit_idx names the data bit currently on the line
               if (tick) begin
                  if (bit_idx == 3'd7) begin
                     bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                     tx      <= parity;
                     state   <= ST_PARITY;
`else
                     tx      <= 1'b1;
                     state   <= ST_STOP;
`endif
                  end else begin
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (tick) begin
                  tx    <= 1'b1;
                  state <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (bit_cnt == DONE_CNT) begin
                  done <= 1'b1;
               end
               if (tick) begin
                  ready <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: begin
               tx    <= 1'b1;
               ready <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - directed self-checking bench for uart_transmitter

module tb_uart_transmitter;

   localparam int N = 434;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   logic       clk_50m = 1'b0;
   logic       rst_n   = 1'b0;
   logic [7:0] data    = 8'h00;
   logic       valid   = 1'b0;
   logic       ready;
   logic       tx;
   logic       busy;
   logic       done;

   int errors = 0;
   int checks = 0;

   uart_transmitter dut (
      .clk_50m (clk_50m),
      .rst_n   (rst_n),
      .data    (data),
      .valid   (valid),
      .ready   (ready),
      .tx      (tx),
      .busy    (busy),
      .done    (done)
   );

   always #10 clk_50m = ~clk_50m;

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_50m);
      #1;
   endtask

   // Line level for frame bit position pos (0 = start bit)
   function automatic logic exp_bit(input logic [7:0] b, input int pos);
      logic [7:0] t;
      if (pos == 0) return 1'b0;
      if (pos <= 8) begin
         t = b >> (pos - 1);
         return t[0];
      end
`ifdef UART_TX_PARITY_EN
      if (pos == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   // Entered at cycle 1 of a frame (1 ns after the accept edge); leaves at the
   // last cycle of the frame. mode 1 scrambles data each cycle, mode 2 pulses
   // valid with 8'h00 in the middle of the frame.
   task automatic run_frame(input string tag, input logic [7:0] b, input int mode);
      int pos;
      int ready_hi;
      int done_early;
      ready_hi   = 0;
      done_early = 0;
      for (int c = 1; c <= FB * N; c++) begin
         if (c > 1) step();
         if (mode == 1) data = 8'($urandom);
         if (mode == 2 && c == 2000) begin
            valid = 1'b1;
            data  = 8'h00;
         end
         if (mode == 2 && c == 2001) valid = 1'b0;
         pos = (c - 1) / N;
         if ((c - 1) % N == 0 || c % N == 0)
            chk_bit($sformatf("%s_pos%0d_c%0d", tag, pos, c), tx, exp_bit(b, pos));
         if (ready) ready_hi++;
         if (done && c != FB * N) done_early++;
      end
      chk_bit({tag, "_done_last"}, done, 1'b1);
      chk_bit({tag, "_busy_last"}, busy, 1'b1);
      chk_int({tag, "_ready_in_frame"}, ready_hi, 0);
      chk_int({tag, "_done_early"}, done_early, 0);
   endtask

   initial begin
      int tx_low;
      int busy_hi;

      // reset state
      #25;
      chk_bit("rst_tx", tx, 1'b1);
      chk_bit("rst_ready", ready, 1'b1);
      chk_bit("rst_busy", busy, 1'b0);
      chk_bit("rst_done", done, 1'b0);
      step();
      step();

      // single byte, accepted on the first edge after reset release
      rst_n = 1'b1;
      data  = 8'h55;
      valid = 1'b1;
      step();
      valid = 1'b0;
      run_frame("f55", 8'h55, 0);
      step();
      chk_bit("f55_ready_after", ready, 1'b1);
      chk_bit("f55_done_after", done, 1'b0);
      chk_bit("f55_tx_idle", tx, 1'b1);

      // back-to-back with valid held high
      data  = 8'hA3;
      valid = 1'b1;
      step();
      data = 8'h0F;
      run_frame("fA3", 8'hA3, 0);
      step();
      chk_bit("b2b_gap_tx", tx, 1'b1);
      chk_bit("b2b_gap_ready", ready, 1'b1);
      step();
      valid = 1'b0;
      run_frame("f0F", 8'h0F, 0);
      step();
      chk_bit("f0F_ready_after", ready, 1'b1);

      // valid while busy is ignored
      data  = 8'hFF;
      valid = 1'b1;
      step();
      valid = 1'b0;
      run_frame("fFF", 8'hFF, 2);
      step();
      chk_bit("fFF_ready_after", ready, 1'b1);
      tx_low  = 0;
      busy_hi = 0;
      for (int i = 0; i < 2 * N; i++) begin
         step();
         if (!tx) tx_low++;
         if (busy) busy_hi++;
      end
      chk_int("fFF_no_second_tx_low", tx_low, 0);
      chk_int("fFF_no_second_busy", busy_hi, 0);

      // reset during data bit 3 of 8'h81
      data  = 8'h81;
      valid = 1'b1;
      step();
      valid = 1'b0;
      repeat (4 * N + 199) step();
      chk_bit("f81_bit3_before_rst", tx, 1'b0);
      chk_bit("f81_busy_before_rst", busy, 1'b1);
      #5;
      rst_n = 1'b0;
      #1;
      chk_bit("f81_async_tx", tx, 1'b1);
      chk_bit("f81_async_ready", ready, 1'b1);
      chk_bit("f81_async_busy", busy, 1'b0);
      chk_bit("f81_async_done", done, 1'b0);
      step();
      step();
      chk_bit("f81_held_tx", tx, 1'b1);
      rst_n = 1'b1;
      data  = 8'h3C;
      valid = 1'b1;
      step();
      valid = 1'b0;
      run_frame("f3C", 8'h3C, 0);
      step();
      chk_bit("f3C_ready_after", ready, 1'b1);

      // data changing after accept does not disturb the frame
      data  = 8'hC6;
      valid = 1'b1;
      step();
      valid = 1'b0;
      run_frame("fC6", 8'hC6, 1);
      step();
      chk_bit("fC6_ready_after", ready, 1'b1);

`ifdef UART_TX_PARITY_EN
      data  = 8'h07;
      valid = 1'b1;
      step();
      valid = 1'b0;
      run_frame("p07", 8'h07, 0);
      step();
      data  = 8'h03;
      valid = 1'b1;
      step();
      valid = 1'b0;
      run_frame("p03", 8'h03, 0);
      step();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
